// File: rtl/divisor_clock_multi_if.sv
// Bundle of the per-channel control inputs and divided-clock outputs of
// divisor_clock_multi.
//   habilita   : per-channel run enable (bit i = channel i)
//   divisor    : per-channel half-period minus one, channel i in [i*LARGURA +: LARGURA]
//   modo_passo : 1 = single-step mode for all channels
//   passo      : single-step request (level; rising edge detected in the DUT)
//   saida      : divided clock per channel
//   tick       : one-cycle pulse in the cycle saida[i] rises
// master drives the controls, slave is the divider.
interface divisor_clock_multi_if #(
  parameter int N_CANAIS = 2,
  parameter int LARGURA  = 8
);
  logic [N_CANAIS-1:0]         habilita;
  logic [N_CANAIS*LARGURA-1:0] divisor;
  logic                        modo_passo;
  logic                        passo;
  logic [N_CANAIS-1:0]         saida;
  logic [N_CANAIS-1:0]         tick;

  modport master (
    output habilita, divisor, modo_passo, passo,
    input  saida, tick
  );

  modport slave (
    input  habilita, divisor, modo_passo, passo,
    output saida, tick
  );
endinterface

// File: rtl/divisor_clock_multi.sv
// divisor_clock_multi: N_CANAIS independent programmable clock dividers.
// Each channel produces saida with half-period D+1 clk cycles (D = its divisor
// slice), plus a one-cycle tick in the cycle saida rises. D is sampled only in
// the first cycle of each half-period.
// Optional single-step mode is compiled in when the macro PASSO_UNICO_EN is
// defined; otherwise modo_passo/passo are accepted but ignored.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : divisor_clock_multi_if.slave (habilita, divisor, modo_passo,
//           passo in; saida, tick out)
module divisor_clock_multi #(
  parameter int N_CANAIS = 2,
  parameter int LARGURA  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  divisor_clock_multi_if.slave bus
);

  typedef enum logic [1:0] {
    LIVRE,
    ESPERA,
    ALTO
  } estado_t;

  estado_t             estado   [N_CANAIS];
  estado_t             estado_n [N_CANAIS];
  logic [LARGURA-1:0]  cont     [N_CANAIS];
  logic [LARGURA-1:0]  cont_n   [N_CANAIS];
  logic [LARGURA-1:0]  sombra   [N_CANAIS];
  logic [LARGURA-1:0]  sombra_n [N_CANAIS];
  logic [LARGURA-1:0]  d_ef     [N_CANAIS];
  logic [N_CANAIS-1:0] saida_r, saida_n;
  logic [N_CANAIS-1:0] tick_r, tick_n;
  logic                modo;
  logic                passo_ok;

`ifdef PASSO_UNICO_EN
  logic passo_q;
  logic modo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      passo_q <= 1'b0;
      modo_q  <= 1'b0;
    end else begin
      passo_q <= bus.passo;
      modo_q  <= bus.modo_passo;
    end
  end

  assign modo = bus.modo_passo;
  // modo_q is still 0 in the cycle step mode is entered, so a passo rise
  // coinciding with modo_passo 0->1 is dropped.
  assign passo_ok = bus.passo & ~passo_q & bus.modo_passo & modo_q;
`else
  logic unused_passo;
  assign unused_passo = bus.modo_passo ^ bus.passo;
  assign modo         = 1'b0;
  assign passo_ok     = 1'b0;
`endif

  // Effective divisor: live input in the first cycle of a half-period,
  // shadow copy for the rest of it.
  always_comb begin
    for (int unsigned i = 0; i < N_CANAIS; i++) begin
      d_ef[i] = (cont[i] == '0) ? bus.divisor[i*LARGURA +: LARGURA] : sombra[i];
    end
  end

  always_comb begin
    saida_n = saida_r;
    tick_n  = '0;
    for (int unsigned i = 0; i < N_CANAIS; i++) begin
      estado_n[i] = estado[i];
      cont_n[i]   = cont[i];
      sombra_n[i] = sombra[i];
      if (cont[i] == '0) begin
        sombra_n[i] = bus.divisor[i*LARGURA +: LARGURA];
      end
      if (!bus.habilita[i]) begin
        cont_n[i]   = '0;
        saida_n[i]  = 1'b0;
        estado_n[i] = modo ? ESPERA : LIVRE;
      end else begin
        unique case (estado[i])
          LIVRE: begin
            // Entering step mode: leave at once when low, otherwise only at
            // the end of the current high phase.
            if (modo && (!saida_r[i] || cont[i] == d_ef[i])) begin
              estado_n[i] = ESPERA;
              cont_n[i]   = '0;
              saida_n[i]  = 1'b0;
            end else if (cont[i] == d_ef[i]) begin
              cont_n[i]  = '0;
              saida_n[i] = ~saida_r[i];
              tick_n[i]  = ~saida_r[i];
            end else begin
              cont_n[i] = cont[i] + LARGURA'(1);
            end
          end
          ESPERA: begin
            cont_n[i]  = '0;
            saida_n[i] = 1'b0;
            if (!modo) begin
              estado_n[i] = LIVRE;
            end else if (passo_ok) begin
              estado_n[i] = ALTO;
              saida_n[i]  = 1'b1;
              tick_n[i]   = 1'b1;
            end
          end
          ALTO: begin
            if (cont[i] == d_ef[i]) begin
              cont_n[i]   = '0;
              saida_n[i]  = 1'b0;
              estado_n[i] = modo ? ESPERA : LIVRE;
            end else begin
              cont_n[i] = cont[i] + LARGURA'(1);
            end
          end
          default: begin
            estado_n[i] = LIVRE;
            cont_n[i]   = '0;
            saida_n[i]  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_r <= '0;
      tick_r  <= '0;
      for (int unsigned i = 0; i < N_CANAIS; i++) begin
        estado[i] <= LIVRE;
        cont[i]   <= '0;
        sombra[i] <= '0;
      end
    end else begin
      saida_r <= saida_n;
      tick_r  <= tick_n;
      for (int unsigned i = 0; i < N_CANAIS; i++) begin
        estado[i] <= estado_n[i];
        cont[i]   <= cont_n[i];
        sombra[i] <= sombra_n[i];
      end
    end
  end

  assign bus.saida = saida_r;
  assign bus.tick  = tick_r;

endmodule

// File: tb/tb_divisor_clock_multi.sv
// Directed self-checking bench for divisor_clock_multi: a 2-channel 8-bit
// instance plus a 1-channel 4-bit instance for the full-range divisor.
// Single-step scenarios are exercised when PASSO_UNICO_EN is defined; in the
// default build the bench checks that modo_passo/passo are ignored instead.
module tb_divisor_clock_multi;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  divisor_clock_multi_if #(.N_CANAIS(2), .LARGURA(8)) bus ();
  divisor_clock_multi_if #(.N_CANAIS(1), .LARGURA(4)) bus4 ();

  divisor_clock_multi #(.N_CANAIS(2), .LARGURA(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  divisor_clock_multi #(.N_CANAIS(1), .LARGURA(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] s0v, t0v, s1v, t1v;
  int unsigned acc, bad, ticks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input int unsigned ch);
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      step();
      if (bus.tick[ch]) got = 1'b1;
    end
    check("rise_found", 32'(got), 32'd1);
  endtask

  task automatic wait_rise4();
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      step();
      if (bus4.tick[0]) got = 1'b1;
    end
    check("rise_found_4b", 32'(got), 32'd1);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.habilita    = '0;
    bus.divisor     = '0;
    bus.modo_passo  = 1'b0;
    bus.passo       = 1'b0;
    bus4.habilita   = 1'b1;
    bus4.divisor    = 4'd15;
    bus4.modo_passo = 1'b0;
    bus4.passo      = 1'b0;

    // Reset state
    step();
    step();
    check("rst_saida", bus.saida, 2'b00);
    check("rst_tick", bus.tick, 2'b00);

    // D0=0, D1=3: periods 2 and 8, one tick per rise
    bus.divisor  = {8'd3, 8'd0};
    bus.habilita = 2'b11;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      s0v[k] = bus.saida[0];
      t0v[k] = bus.tick[0];
      s1v[k] = bus.saida[1];
      t1v[k] = bus.tick[1];
    end
    check("trace_saida0", 32'(s0v), 32'h5555);
    check("trace_tick0", 32'(t0v), 32'h5555);
    check("trace_saida1", 32'(s1v), 32'h7878);
    check("trace_tick1", 32'(t1v), 32'h0808);

    // D1 3->1 during a high phase: this half stays 4, then 2-cycle halves
    wait_rise(1);
    step();
    bus.divisor = {8'd1, 8'd0};
    s1v = '0;
    t1v = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      s1v[k] = bus.saida[1];
      t1v[k] = bus.tick[1];
    end
    check("dchg_saida1", 32'(s1v[7:0]), 32'h33);
    check("dchg_tick1", 32'(t1v[7:0]), 32'h10);

    // Drop habilita[1] while high, then re-enable with D=3
    wait_rise(1);
    bus.habilita = 2'b01;
    step();
    check("dis_saida1", 32'(bus.saida[1]), 32'd0);
    check("dis_tick1", 32'(bus.tick[1]), 32'd0);
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      acc = acc | 32'(bus.saida[1]) | 32'(bus.tick[1]);
    end
    check("dis_quiet1", acc, 0);
    bus.divisor  = {8'd3, 8'd0};
    bus.habilita = 2'b11;
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      acc = acc | 32'(bus.saida[1]) | 32'(bus.tick[1]);
    end
    check("reen_low1", acc, 0);
    step();
    check("reen_rise_saida1", 32'(bus.saida[1]), 32'd1);
    check("reen_rise_tick1", 32'(bus.tick[1]), 32'd1);

    // 4-bit channel, D=15: period 32 over 1024 cycles
    wait_rise4();
    bad   = 0;
    ticks = 0;
    for (int k = 1; k <= 1024; k++) begin
      step();
      if (bus4.saida[0] !== ((k % 32) < 16)) bad++;
      if (bus4.tick[0] !== ((k % 32) == 0)) bad++;
      if (bus4.tick[0]) ticks++;
    end
    check("ext_wave_errs", bad, 0);
    check("ext_ticks", ticks, 32);

`ifdef PASSO_UNICO_EN
    // Enter step mode with a coincident passo rise: ignored, channels park low
    bus.divisor    = {8'd3, 8'd2};
    bus.modo_passo = 1'b1;
    bus.passo      = 1'b1;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      acc = acc | 32'(bus.tick);
    end
    check("step_entry_ticks", acc, 0);
    check("step_entry_saida", bus.saida, 2'b00);
    bus.passo = 1'b0;
    step();
    step();

    // Three passo pulses 10 cycles apart; the second carries an extra rise
    // inside the high phase that must be ignored
    ticks = 0;
    for (int p = 0; p < 3; p++) begin
      s0v = '0; t0v = '0; s1v = '0; t1v = '0;
      for (int k = 1; k <= 10; k++) begin
        bus.passo = (k == 1) || (p == 1 && k == 3);
        step();
        s0v[k-1] = bus.saida[0];
        t0v[k-1] = bus.tick[0];
        s1v[k-1] = bus.saida[1];
        t1v[k-1] = bus.tick[1];
        if (bus.tick[0]) ticks++;
      end
      check("step_saida0", 32'(s0v[9:0]), 32'h007);
      check("step_tick0", 32'(t0v[9:0]), 32'h001);
      check("step_saida1", 32'(s1v[9:0]), 32'h00F);
      check("step_tick1", 32'(t1v[9:0]), 32'h001);
    end
    check("step_tick_count", ticks, 3);

    // Asynchronous reset in the middle of a high step
    bus.passo = 1'b1;
    step();
    check("alto_entry", bus.saida, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_saida", bus.saida, 2'b00);
    check("rst_async_tick", bus.tick, 2'b00);
`else
    // Step inputs have no effect without the step-mode build
    wait_rise(1);
    bus.modo_passo = 1'b1;
    s1v = '0;
    t1v = '0;
    for (int k = 0; k < 8; k++) begin
      bus.passo = k[0];
      step();
      s1v[k] = bus.saida[1];
      t1v[k] = bus.tick[1];
    end
    check("nostep_saida1", 32'(s1v[7:0]), 32'h87);
    check("nostep_tick1", 32'(t1v[7:0]), 32'h80);

    // Asynchronous reset in the middle of a high phase
    wait_rise(1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_saida", bus.saida, 2'b00);
    check("rst_async_tick", bus.tick, 2'b00);
`endif

    // Restart after reset: D0=2 rises on 3rd edge, D1=3 on 4th
    bus.passo      = 1'b0;
    bus.modo_passo = 1'b0;
    bus.divisor    = {8'd3, 8'd2};
    step();
    check("rst_hold_saida", bus.saida, 2'b00);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("restart_e2_saida", bus.saida, 2'b00);
    step();
    check("restart_e3_saida", bus.saida, 2'b01);
    check("restart_e3_tick", bus.tick, 2'b01);
    step();
    check("restart_e4_saida", bus.saida, 2'b11);
    check("restart_e4_tick", bus.tick, 2'b10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/divisor_clock_multi.md
DIVISOR_CLOCK_MULTI -- requirements
Module: divisor_clock_multi

Interface
REQ-001 Parameter N_CANAIS, default 2: number of independent divided-clock channels, 1..8.
REQ-002 Parameter LARGURA, default 8: width of each channel's divisor and counter, 2..16.
REQ-003 Port clk  input  1: single system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port habilita  input  N_CANAIS: per-channel run enable, bit i = channel i.
REQ-006 Port divisor  input  N_CANAIS*LARGURA: per-channel half-period minus one (D); channel i in bits [i*LARGURA +: LARGURA].
REQ-007 Port modo_passo  input  1: 1 = single-step mode for all channels, 0 = free-running.
REQ-008 Port passo  input  1: single-step request, level input, rising edge detected internally.
REQ-009 Port saida  output  N_CANAIS: divided clock per channel, registered.
REQ-010 Port tick  output  N_CANAIS: one-clk pulse, high in the same cycle saida[i] goes 0->1.

Function
REQ-011 Each channel SHALL own a LARGURA-bit counter cont, a divisor shadow register and a 3-state FSM: LIVRE, ESPERA, ALTO.
REQ-012 Divisor sampling: divisor[i] SHALL be captured only on the first cycle of each half-period (cont==0); mid-half-period changes take effect at the next half-period.
REQ-013 LIVRE: cont increments each cycle; when cont==D_shadow, cont wraps to 0 and saida toggles next edge; half-period = D+1 cycles, period = 2*(D+1).
REQ-014 D=0 SHALL yield saida = clk/2 (toggle every cycle); D=2^LARGURA-1 SHALL count the full range without overflow error.
REQ-015 habilita[i]=0: cont[i] forced to 0, saida[i] forced to 0 on the next edge, tick[i]=0, FSM to LIVRE (or ESPERA in step mode).
REQ-016 habilita[i] 0->1: first saida[i] rising edge SHALL occur D+1 cycles after the first enabled cycle.
REQ-017 tick[i] SHALL be high for exactly one cycle per saida[i] rising transition and never otherwise.
REQ-018 modo_passo 0->1: each channel SHALL finish its current high phase (if any), then enter ESPERA with saida=0, cont=0.
REQ-019 ESPERA: on a detected passo rising edge (passo=1, previous sample 0), channel enters ALTO; saida=1 and tick=1 on the next edge.
REQ-020 ALTO: saida held 1 for exactly D+1 cycles, then return to ESPERA with saida=0; passo edges during ALTO SHALL be ignored, not queued.
REQ-021 modo_passo 1->0: channels in ESPERA SHALL go to LIVRE with cont=0, saida=0; channels in ALTO complete the high phase, then LIVRE low phase.
REQ-022 Passo rising edge coincident with modo_passo 0->1 SHALL be ignored.
REQ-023 Channels SHALL be fully independent except for shared modo_passo/passo.

Reset
REQ-024 rst_n=0 SHALL immediately clear saida, tick, all cont, all shadows and the passo edge register, and set all FSMs to LIVRE.
REQ-025 Reset asserted mid-high-phase or mid-step SHALL abort it with no further tick.
REQ-026 After rst_n deasserts, first saida rise per enabled channel SHALL occur D+1 cycles after the first sampling edge.

Configuration
REQ-027 Macro PASSO_UNICO_EN defined: single-step mode (REQ-018..REQ-022) compiled in.
REQ-028 PASSO_UNICO_EN undefined: modo_passo and passo ports SHALL remain but be ignored; FSM reduces to LIVRE; behaviour identical to modo_passo=0.

Verification
REQ-029 N_CANAIS=2, LARGURA=8, D0=0, D1=3, both enabled -> saida[0] period 2 cycles, saida[1] period 8 cycles, one tick per rise each.
REQ-030 D1 changed 3->1 mid-high-phase -> current half-period stays 4 cycles, following half-periods 2 cycles.
REQ-031 habilita[1] dropped while saida[1]=1 -> saida[1]=0 next edge, no tick; re-enable with D=3 -> first rise 4 cycles later.
REQ-032 PASSO_UNICO_EN, modo_passo=1, D0=2, three passo pulses 10 cycles apart -> three 3-cycle high pulses on saida[0], three ticks; a pulse inside ALTO yields none.
REQ-033 rst_n pulsed low asynchronously mid-cycle during ALTO -> saida, tick clear before the next clk edge; restart per REQ-026.
REQ-034 Extremes: LARGURA=4, D=15 -> period 32 cycles over 1000 cycles, no glitch or missed toggle at cont wrap.
